// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: MEM/WB bundle layout,
// pack/unpack helpers and the occupancy state encoding.
package pipe_pkg;

    localparam int unsigned PIPE_MEMWB_W = 104;

    // Bit offsets of the MEM/WB bundle fields (LSB positions)
    localparam int unsigned OFF_EXTEND  = 0;
    localparam int unsigned OFF_PC      = 32;
    localparam int unsigned OFF_ALUOUT  = 64;
    localparam int unsigned OFF_CMP     = 96;
    localparam int unsigned OFF_IMMRES  = 98;
    localparam int unsigned OFF_DIGIT   = 99;
    localparam int unsigned OFF_REGWR   = 101;
    localparam int unsigned OFF_REGDST  = 102;

    // Field order is MSB first, so it lines up with the offsets above
    typedef struct packed {
        logic [1:0]  reg_dst;
        logic        reg_wr;
        logic [1:0]  digit;
        logic        immres;
        logic [1:0]  cmp;
        logic [31:0] alu_output;
        logic [31:0] pc;
        logic [31:0] extend;
    } memwb_t;

    // Occupancy doubles as the state encoding
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    function automatic logic [PIPE_MEMWB_W-1:0] pack_memwb(input memwb_t b);
        return PIPE_MEMWB_W'(b);
    endfunction

    function automatic memwb_t unpack_memwb(input logic [PIPE_MEMWB_W-1:0] v);
        return memwb_t'(v);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; state updates on the falling clock edge.
// Ports: clk, rst (async active-high), en_i (count this edge), cnt_o (count value).
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, stall counter
// and an optional second (skid) entry. State updates on the falling clock edge.
// Ports:
//   clk, rst (async active-high), flush (drop all entries this edge)
//   in_valid/in_ready/in_data    upstream handshake and bundle
//   out_valid/out_ready/out_data downstream handshake and bundle
//   occ        entries held (0..2)
//   stall_cnt  saturating count of edges with out_valid && !out_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = PIPE_MEMWB_W,
    parameter bit          SKID_EN = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    occ_state_e       state_q;
    logic [WIDTH-1:0] main_q;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign occ       = 2'(state_q);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    generate
        if (SKID_EN) begin : g_skid
            logic [WIDTH-1:0] skid_q;

            // Only depends on state, so upstream sees no combinational path from out_ready
            assign in_ready = !rst && !flush && (state_q != OCC_FULL);

            // Occupancy FSM; main always holds the older entry
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= OCC_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else if (flush) begin
                    state_q <= OCC_EMPTY;
                end else begin
                    case (state_q)
                        OCC_EMPTY: begin
                            if (in_xfer) begin
                                state_q <= OCC_ONE;
                                main_q  <= in_data;
                            end
                        end
                        OCC_ONE: begin
                            if (in_xfer && out_xfer) begin
                                main_q <= in_data;
                            end else if (in_xfer) begin
                                state_q <= OCC_FULL;
                                skid_q  <= in_data;
                            end else if (out_xfer) begin
                                state_q <= OCC_EMPTY;
                            end
                        end
                        OCC_FULL: begin
                            if (out_xfer) begin
                                state_q <= OCC_ONE;
                                main_q  <= skid_q;
                            end
                        end
                        default: state_q <= OCC_EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            // Accept when empty or when the held entry leaves on the same edge
            assign in_ready = !rst && !flush && (!out_valid || out_ready);

            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= OCC_EMPTY;
                    main_q  <= '0;
                end else if (flush) begin
                    state_q <= OCC_EMPTY;
                end else if (in_xfer) begin
                    state_q <= OCC_ONE;
                    main_q  <= in_data;
                end else if (out_xfer) begin
                    state_q <= OCC_EMPTY;
                end
            end
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (out_valid && !out_ready),
        .cnt_o(stall_cnt)
    );

endmodule
